serial2parallel: RTL



---
 rtl/serial2parallel_pkg.sv | 26 ++
 rtl/serial2parallel_if.sv | 25 ++
 rtl/serial2parallel_input_stage.sv | 52 +++++
 rtl/serial2parallel.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/serial2parallel_pkg.sv
// Shared definitions for the serial-to-parallel receiver: FSM states, endian
// selectors and the width helper used to size the internal counters.
package serial2parallel_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2
  } s2p_state_e;

  localparam int unsigned ENDIAN_LITTLE = 32'd0;
  localparam int unsigned ENDIAN_BIG    = 32'd1;

  // Number of bits needed to hold 'value' (at least one).
  function automatic int unsigned get_width(input int unsigned value);
    int unsigned w;
    w = 32'd1;
    for (int i = 1; i < 32; i++) begin
      if ((value >> i) != 32'd0) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/serial2parallel_if.sv
// Bundle of the three-wire serial link inputs and the parallel word outputs.
// The master side drives the serial lines; the slave side is the receiver.
interface serial2parallel_if #(
  parameter int unsigned DATA_BITS = 32
);

  logic                 s_clk;
  logic                 s_clr;
  logic                 s_dat;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 busy;
  logic                 error;

  modport master (
    output s_clk, s_clr, s_dat,
    input  data, valid, busy, error
  );

  modport slave (
    input  s_clk, s_clr, s_dat,
    output data, valid, busy, error
  );

endinterface

// File: rtl/serial2parallel_input_stage.sv
// Input capture for the serial link: a register chain per line plus s_clk edge
// detection. S2P_INPUT_SYNC_EN selects a two-flop synchronizer instead of one flop.
module s2p_input_stage (
  input  logic clk,
  input  logic rst,
  input  logic s_clk_i,
  input  logic s_clr_i,
  input  logic s_dat_i,
  output logic s_clr_o,
  output logic s_dat_o,
  output logic rise_o
);

`ifdef S2P_INPUT_SYNC_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  // Each chain entry carries {s_clk, s_clr, s_dat}.
  logic [2:0] chain_q [DEPTH];
  logic [2:0] chain_d [DEPTH];
  logic       prev_q;
  logic       prev_d;

  // Next value of every stage and of the previous-s_clk flop.
  always_comb begin
    chain_d[0] = {s_clk_i, s_clr_i, s_dat_i};
    for (int i = 1; i < DEPTH; i++) begin
      chain_d[i] = chain_q[i-1];
    end
    prev_d = chain_q[DEPTH-1][2];
  end

  // Input chain and previous-s_clk registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        chain_q[i] <= 3'b000;
      end
      prev_q <= 1'b0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign s_clr_o = chain_q[DEPTH-1][1];
  assign s_dat_o = chain_q[DEPTH-1][0];
  assign rise_o  = chain_q[DEPTH-1][2] & ~prev_q;

endmodule

// File: rtl/serial2parallel.sv
// Receiver for the three-wire serial link: oversamples s_clk/s_clr/s_dat, shifts
// in DATA_BITS bits per frame and presents the word with a one-cycle valid pulse.
module serial2parallel
  import serial2parallel_pkg::*;
#(
  parameter int unsigned DATA_BITS      = 32,
  parameter int unsigned CODE_ENDIAN    = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic               clk,
  input logic               rst,
  serial2parallel_if.slave  bus
);

  localparam int unsigned CNT_W = get_width(DATA_BITS - 1);
  localparam int unsigned TMO_W = get_width(TIMEOUT_CYCLES - 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1'b1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_BITS-1:0] WORD_ZERO = {DATA_BITS{1'b0}};

  logic clr_s;
  logic dat_s;
  logic rise_s;

  s2p_input_stage u_input_stage (
    .clk     (clk),
    .rst     (rst),
    .s_clk_i (bus.s_clk),
    .s_clr_i (bus.s_clr),
    .s_dat_i (bus.s_dat),
    .s_clr_o (clr_s),
    .s_dat_o (dat_s),
    .rise_o  (rise_s)
  );

  s2p_state_e           state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [TMO_W-1:0]     tmo_q,   tmo_d;
  logic [DATA_BITS-1:0] data_q,  data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q,  busy_d;
  logic                 error_q, error_d;

  // Little-endian shifts right with the new bit at the MSB, so the first bit
  // lands in bit 0; big-endian shifts left so the first bit ends at the MSB.
  function automatic logic [DATA_BITS-1:0] shift_in(
    input logic [DATA_BITS-1:0] cur,
    input logic                 bit_in
  );
    if (CODE_ENDIAN == ENDIAN_BIG) begin
      return {cur[DATA_BITS-2:0], bit_in};
    end else begin
      return {bit_in, cur[DATA_BITS-1:1]};
    end
  endfunction

  // Frame FSM: next state, shift/count/timeout updates and output values.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    valid_d = 1'b0;
    error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (clr_s) begin
          state_d = S_RECV;
          shift_d = WORD_ZERO;
          cnt_d   = CNT_ZERO;
          tmo_d   = TMO_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RECV: begin
        if (clr_s) begin
          // Clear beats a simultaneous edge; a clear after some bits is an abort.
          shift_d = WORD_ZERO;
          cnt_d   = CNT_ZERO;
          tmo_d   = TMO_ZERO;
          if (cnt_q != CNT_ZERO) begin
            error_d = 1'b1;
          end else begin
            error_d = 1'b0;
          end
        end else if (rise_s) begin
          shift_d = shift_in(shift_q, dat_s);
          tmo_d   = TMO_ZERO;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = CNT_ZERO;
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else if (tmo_q == TMO_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
          tmo_d   = TMO_ZERO;
        end else begin
          tmo_d   = tmo_q + TMO_ONE;
        end
      end

      S_DONE: begin
        data_d  = shift_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        shift_d = WORD_ZERO;
        cnt_d   = CNT_ZERO;
        tmo_d   = TMO_ZERO;
      end
    endcase

    busy_d = (state_d == S_RECV);
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shift_q <= WORD_ZERO;
      cnt_q   <= CNT_ZERO;
      tmo_q   <= TMO_ZERO;
      data_q  <= WORD_ZERO;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      error_q <= error_d;
    end
  end

  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.error = error_q;

endmodule
